// File: rtl/sb_3320_motor_ramp_control_pkg.sv
// Shared encodings for the motor ramp controller: command codes, channel FSM
// states and direction values.
package sb_3320_motor_pkg;

    typedef enum logic [2:0] {
        CMD_STOP    = 3'b000,
        CMD_FWD     = 3'b001,
        CMD_LEFT    = 3'b010,
        CMD_RIGHT   = 3'b011,
        CMD_EXTREME = 3'b100
    } cmd_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } chan_state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/sb_3320_motor_ramp_control_if.sv
// Command and pin bundle between the motor ramp controller and its user.
interface sb_3320_motor_ramp_control_if;
    logic [2:0] turn;
    logic       enable;
    logic       left_motor;
    logic       right_motor;
    logic       gndl;
    logic       gndr;
    logic       settled;

    modport master (
        output turn, enable,
        input  left_motor, right_motor, gndl, gndr, settled
    );

    modport slave (
        input  turn, enable,
        output left_motor, right_motor, gndl, gndr, settled
    );
endinterface

// File: rtl/sb_3320_motor_ramp_control_channel.sv
// One motor side: magnitude ramp, reversal dead time and glitch-free PWM pin drive.
module sb_3320_motor_channel
    import sb_3320_motor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int RAMP_STEP = 1,
    parameter int DEAD_CYC  = 5000
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             pwm_wrap,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] tgt_mag,
    input  logic             tgt_dir,
    output logic             motor_pin,
    output logic             gnd_pin,
    output logic             at_target
);

    localparam int               STEP_C    = (RAMP_STEP > (1 << PWM_W) - 1) ? (1 << PWM_W) - 1 : RAMP_STEP;
    localparam logic [PWM_W-1:0] STEP_V    = PWM_W'(STEP_C);
    localparam int               DW        = $clog2(DEAD_CYC + 1);
    localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CYC - 1);

    chan_state_e      state;
    logic [PWM_W-1:0] mag;
    logic [PWM_W-1:0] duty_q;
    logic             dir;
    logic             dir_q;
    logic [DW-1:0]    dead_cnt;

    logic             want_flip;
    logic             enter_dead;
    logic [PWM_W-1:0] mag_next;

    // A reversal first bleeds magnitude to zero; otherwise step toward target without overshoot.
    always_comb begin
        want_flip  = (tgt_mag != '0) && (tgt_dir != dir);
        enter_dead = (state == ST_RUN) && want_flip && (mag == '0);
        mag_next   = mag;
        if (want_flip) begin
            mag_next = (mag > STEP_V) ? mag - STEP_V : '0;
        end else if (mag < tgt_mag) begin
            mag_next = ((tgt_mag - mag) > STEP_V) ? mag + STEP_V : tgt_mag;
        end else if (mag > tgt_mag) begin
            mag_next = ((mag - tgt_mag) > STEP_V) ? mag - STEP_V : tgt_mag;
        end
    end

    always_comb begin
        at_target = (state == ST_RUN) && (mag == tgt_mag) &&
                    ((dir == tgt_dir) || (tgt_mag == '0));
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            mag       <= '0;
            dir       <= DIR_FWD;
            dead_cnt  <= '0;
            duty_q    <= '0;
            dir_q     <= DIR_FWD;
            motor_pin <= 1'b0;
            gnd_pin   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (enter_dead) begin
                        state    <= ST_DEAD;
                        dead_cnt <= '0;
                    end else if (tick) begin
                        mag <= mag_next;
                    end
                end
                ST_DEAD: begin
                    if (!want_flip) begin
                        state <= ST_RUN;
                    end else if (dead_cnt == DEAD_LAST) begin
                        state <= ST_RUN;
                        dir   <= ~dir;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase

            // Applied duty only moves at the PWM wrap, except dead time which blanks at once.
            if (enter_dead || (state == ST_DEAD)) begin
                duty_q    <= '0;
                motor_pin <= 1'b0;
                gnd_pin   <= 1'b0;
            end else begin
                if (pwm_wrap) begin
                    duty_q <= mag;
                    dir_q  <= dir;
                end
                motor_pin <= (dir_q == DIR_FWD) && (pwm_cnt < duty_q);
                gnd_pin   <= (dir_q == DIR_REV) && (pwm_cnt < duty_q);
            end
        end
    end

endmodule

// File: rtl/sb_3320_motor_ramp_control.sv
// Two-side motor controller: command decode, shared ramp prescaler and PWM counter,
// and one ramping channel per side.
module sb_3320_motor_ramp_control
    import sb_3320_motor_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter int DUTY_FWD   = 83,
    parameter int DUTY_EXT_L = 84,
    parameter int DUTY_EXT_R = 77,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 1,
    parameter int DEAD_CYC   = 5000
) (
    input logic                        clk_50,
    input logic                        rst_n,
    sb_3320_motor_ramp_control_if.slave bus
);

    localparam int               PW       = $clog2(RAMP_DIV + 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [PWM_W-1:0] FWD_V    = PWM_W'(DUTY_FWD);
    localparam logic [PWM_W-1:0] EXTL_V   = PWM_W'(DUTY_EXT_L);
    localparam logic [PWM_W-1:0] EXTR_V   = PWM_W'(DUTY_EXT_R);

    logic [PW-1:0]    presc;
    logic [PWM_W-1:0] pwm_cnt;
    logic             tick;
    logic             pwm_wrap;

    logic [PWM_W-1:0] tgt_l_mag, tgt_r_mag, tgt_l_mag_d, tgt_r_mag_d;
    logic             tgt_l_dir, tgt_r_dir, tgt_l_dir_d, tgt_r_dir_d;
    logic             l_motor, l_gnd, r_motor, r_gnd, l_at, r_at;
    logic             settled_q;

    assign tick     = (presc == PRE_LAST);
    assign pwm_wrap = (pwm_cnt == '1);

    // Unknown codes and a low enable both fall back to a zero target.
    always_comb begin
        tgt_l_mag_d = '0;
        tgt_r_mag_d = '0;
        tgt_l_dir_d = DIR_FWD;
        tgt_r_dir_d = DIR_FWD;
        if (bus.enable) begin
            case (bus.turn)
                CMD_FWD: begin
                    tgt_l_mag_d = FWD_V;
                    tgt_r_mag_d = FWD_V;
                end
                CMD_LEFT: begin
                    tgt_l_mag_d = FWD_V;
                    tgt_l_dir_d = DIR_REV;
                    tgt_r_mag_d = FWD_V;
                end
                CMD_RIGHT: begin
                    tgt_l_mag_d = FWD_V;
                    tgt_r_mag_d = FWD_V;
                    tgt_r_dir_d = DIR_REV;
                end
                CMD_EXTREME: begin
                    tgt_l_mag_d = EXTL_V;
                    tgt_l_dir_d = DIR_REV;
                    tgt_r_mag_d = EXTR_V;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            tgt_l_mag <= '0;
            tgt_r_mag <= '0;
            tgt_l_dir <= DIR_FWD;
            tgt_r_dir <= DIR_FWD;
            settled_q <= 1'b1;
        end else begin
            presc     <= tick ? '0 : presc + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            tgt_l_mag <= tgt_l_mag_d;
            tgt_r_mag <= tgt_r_mag_d;
            tgt_l_dir <= tgt_l_dir_d;
            tgt_r_dir <= tgt_r_dir_d;
            settled_q <= l_at && r_at;
        end
    end

    sb_3320_motor_channel #(
        .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)
    ) u_left (
        .clk_50(clk_50), .rst_n(rst_n), .tick(tick), .pwm_wrap(pwm_wrap),
        .pwm_cnt(pwm_cnt), .tgt_mag(tgt_l_mag), .tgt_dir(tgt_l_dir),
        .motor_pin(l_motor), .gnd_pin(l_gnd), .at_target(l_at)
    );

    sb_3320_motor_channel #(
        .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)
    ) u_right (
        .clk_50(clk_50), .rst_n(rst_n), .tick(tick), .pwm_wrap(pwm_wrap),
        .pwm_cnt(pwm_cnt), .tgt_mag(tgt_r_mag), .tgt_dir(tgt_r_dir),
        .motor_pin(r_motor), .gnd_pin(r_gnd), .at_target(r_at)
    );

    assign bus.left_motor  = l_motor;
    assign bus.gndl        = l_gnd;
    assign bus.right_motor = r_motor;
    assign bus.gndr        = r_gnd;
    assign bus.settled     = settled_q;

endmodule

// File: tb/tb_sb_3320_motor_ramp_control.sv
// Directed bench for the motor ramp controller with small parameters
// (PWM_W=4, RAMP_DIV=4, RAMP_STEP=2, DEAD_CYC=8, F=9, EXT_L=10, EXT_R=7).
module tb_sb_3320_motor_ramp_control;
    import sb_3320_motor_pkg::*;

    logic clk_50 = 1'b0;
    logic rst_n;

    always #10 clk_50 = ~clk_50;

    sb_3320_motor_ramp_control_if bus();

    sb_3320_motor_ramp_control #(
        .PWM_W(4), .DUTY_FWD(9), .DUTY_EXT_L(10), .DUTY_EXT_R(7),
        .RAMP_DIV(4), .RAMP_STEP(2), .DEAD_CYC(8)
    ) dut (
        .clk_50(clk_50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] turn;
        logic       enable;
        int         lm, lg, rm, rg;
        logic       settled;
    } vec_t;

    vec_t vecs[12];
    int   total   = 0;
    int   bad     = 0;
    int   overlap = 0;

    always @(negedge clk_50) begin
        if ((bus.left_motor && bus.gndl) || (bus.right_motor && bus.gndr)) overlap++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] t, input logic en);
        @(negedge clk_50);
        bus.turn   = t;
        bus.enable = en;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    // High-cycle counts over one full 16-cycle PWM period.
    task automatic measure(output int lm, output int lg, output int rm, output int rg);
        lm = 0; lg = 0; rm = 0; rg = 0;
        repeat (16) begin
            @(negedge clk_50);
            lm += int'(bus.left_motor);
            lg += int'(bus.gndl);
            rm += int'(bus.right_motor);
            rg += int'(bus.gndr);
        end
    endtask

    initial begin
        int lm, lg, rm, rg;
        int ramp_exp[4];
        int prev, got, idx, cyc, dead_cycles, last_motor, first_gnd, gndr_hi, found;

        vecs[0]  = '{3'b000, 1'b1, 0, 0,  0, 0, 1'b1};
        vecs[1]  = '{3'b100, 1'b1, 0, 10, 7, 0, 1'b1};
        vecs[2]  = '{3'b100, 1'b0, 0, 0,  0, 0, 1'b1};
        vecs[3]  = '{3'b001, 1'b1, 9, 0,  9, 0, 1'b1};
        vecs[4]  = '{3'b010, 1'b1, 0, 9,  9, 0, 1'b1};
        vecs[5]  = '{3'b011, 1'b1, 9, 0,  0, 9, 1'b1};
        vecs[6]  = '{3'b100, 1'b1, 0, 10, 7, 0, 1'b1};
        vecs[7]  = '{3'b111, 1'b1, 0, 0,  0, 0, 1'b1};
        vecs[8]  = '{3'b001, 1'b1, 9, 0,  9, 0, 1'b1};
        vecs[9]  = '{3'b101, 1'b1, 0, 0,  0, 0, 1'b1};
        vecs[10] = '{3'b110, 1'b1, 0, 0,  0, 0, 1'b1};
        vecs[11] = '{3'b011, 1'b0, 0, 0,  0, 0, 1'b1};
        ramp_exp = '{4, 6, 8, 9};

        // Reset state
        rst_n      = 1'b0;
        bus.turn   = 3'b000;
        bus.enable = 1'b0;
        waitCycles(3);
        checkOutput("reset_pins", int'(bus.left_motor) + int'(bus.gndl) + int'(bus.right_motor) + int'(bus.gndr), 0);
        checkOutput("reset_settled", int'(bus.settled), 1);

        // Forward ramp from reset: first tick RAMP_DIV cycles after release
        bus.turn   = 3'b001;
        bus.enable = 1'b1;
        @(negedge clk_50);
        rst_n = 1'b1;
        waitCycles(3);
        checkOutput("ramp_before_first_tick", int'(dut.u_left.mag), 0);
        checkOutput("ramp_settled_low", int'(bus.settled), 0);
        waitCycles(1);
        checkOutput("ramp_first_tick", int'(dut.u_left.mag), 2);
        prev = 2;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int c = 0; c < 40 && got < 0; c++) begin
                @(negedge clk_50);
                if (int'(dut.u_left.mag) != prev) got = int'(dut.u_left.mag);
            end
            checkOutput($sformatf("ramp_step_%0d", k), got, ramp_exp[k]);
            if (got >= 0) prev = got;
        end
        waitCycles(40);
        checkOutput("ramp_hold_at_target", int'(dut.u_left.mag), 9);
        checkOutput("ramp_settled_high", int'(bus.settled), 1);
        measure(lm, lg, rm, rg);
        checkOutput("fwd_left_motor_duty", lm, 9);
        checkOutput("fwd_gndl_duty", lg, 0);

        // Forward to left turn: left reverses through exactly DEAD_CYC dead cycles
        applyStimulus(3'b010, 1'b1);
        dead_cycles = 0; last_motor = -1; first_gnd = -1; gndr_hi = 0;
        for (cyc = 0; cyc < 300 && first_gnd < 0; cyc++) begin
            @(negedge clk_50);
            if (dut.u_left.state == ST_DEAD) dead_cycles++;
            if (bus.left_motor) last_motor = cyc;
            if (bus.gndl) first_gnd = cyc;
            if (bus.gndr) gndr_hi++;
        end
        checkOutput("rev_gndl_seen", int'(first_gnd >= 0), 1);
        checkOutput("rev_dead_cycles", dead_cycles, 8);
        checkOutput("rev_low_gap_ge_dead", int'((first_gnd - last_motor - 1) >= 8), 1);
        checkOutput("rev_gndr_quiet", gndr_hi, 0);
        waitCycles(100);
        measure(lm, lg, rm, rg);
        checkOutput("rev_left_motor_duty", lm, 0);
        checkOutput("rev_gndl_duty", lg, 9);
        checkOutput("rev_right_motor_duty", rm, 9);

        // Abort dead time by returning to forward
        applyStimulus(3'b001, 1'b1);
        waitCycles(100);
        applyStimulus(3'b010, 1'b1);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk_50);
            if (dut.u_left.state == ST_DEAD) found = 1;
        end
        checkOutput("abort_dead_reached", found, 1);
        bus.turn = 3'b001;
        waitCycles(2);
        checkOutput("abort_back_to_run", int'(dut.u_left.state), int'(ST_RUN));
        checkOutput("abort_dir_kept", int'(dut.u_left.dir), int'(DIR_FWD));
        waitCycles(100);
        measure(lm, lg, rm, rg);
        checkOutput("abort_left_motor_duty", lm, 9);
        checkOutput("abort_gndl_duty", lg, 0);

        // Table of steady-state commands, applied in sequence
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].turn, vecs[i].enable);
            waitCycles(200);
            measure(lm, lg, rm, rg);
            checkOutput($sformatf("vec%0d_left_motor", i), lm, vecs[i].lm);
            checkOutput($sformatf("vec%0d_gndl", i), lg, vecs[i].lg);
            checkOutput($sformatf("vec%0d_right_motor", i), rm, vecs[i].rm);
            checkOutput($sformatf("vec%0d_gndr", i), rg, vecs[i].rg);
            checkOutput($sformatf("vec%0d_settled", i), int'(bus.settled), int'(vecs[i].settled));
        end

        // Asynchronous reset while a pin is high
        applyStimulus(3'b001, 1'b1);
        waitCycles(5 + int'($urandom_range(0, 20)));
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk_50);
            if (bus.left_motor) found = 1;
        end
        checkOutput("arst_pin_was_high", found, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pins_low", int'(bus.left_motor) + int'(bus.gndl) + int'(bus.right_motor) + int'(bus.gndr), 0);
        checkOutput("arst_settled", int'(bus.settled), 1);
        checkOutput("arst_mag", int'(dut.u_left.mag), 0);
        bus.turn = 3'b111;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(100);
        measure(lm, lg, rm, rg);
        checkOutput("post_rst_111_pins", lm + lg + rm + rg, 0);
        checkOutput("post_rst_111_settled", int'(bus.settled), 1);

        checkOutput("pin_pair_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sb_3320_motor_ramp_control.md
SB_3320_MOTOR_RAMP_CONTROL -- requirements
Module: SB_3320_motor_ramp_control

Interface
REQ-001 SHALL: PWM_W, 8, PWM counter/duty width; PWM period = 2^PWM_W clk_50 cycles.
REQ-002 SHALL: DUTY_FWD, 83, magnitude for forward/left/right commands.
REQ-003 SHALL: DUTY_EXT_L, 84, left reverse magnitude for extreme command.
REQ-004 SHALL: DUTY_EXT_R, 77, right forward magnitude for extreme command.
REQ-005 SHALL: RAMP_DIV, 50000, clk_50 cycles per ramp tick (>=1).
REQ-006 SHALL: RAMP_STEP, 1, magnitude change per ramp tick (>=1).
REQ-007 SHALL: DEAD_CYC, 5000, clk_50 cycles with both pins low on direction reversal (>=1).
REQ-008 SHALL: clk_50  in  1  system clock, all logic on rising edge.
REQ-009 SHALL: rst_n  in  1  asynchronous active-low reset.
REQ-010 SHALL: turn  in  3  command: 000 stop, 001 forward, 010 left, 011 right, 100 extreme, others stop.
REQ-011 SHALL: enable  in  1  high = follow turn; low = all targets zero.
REQ-012 SHALL: left_motor, right_motor  out  1 each  forward-pin PWM per side.
REQ-013 SHALL: gndl, gndr  out  1 each  reverse-pin PWM per side.
REQ-014 SHALL: settled  out  1  high when both sides are at target and neither is in dead time.

Function
REQ-015 SHALL: map each command to signed side targets (L,R): stop (0,0); forward (+F,+F); left (-F,+F); right (+F,-F); extreme (-EXT_L,+EXT_R); F = DUTY_FWD.
REQ-016 SHALL: register targets from turn/enable every cycle (1-cycle latency).
REQ-017 SHALL: generate one shared free-running PWM_W-bit counter; pin high while counter < applied duty; duty 0 gives constant low.
REQ-018 SHALL: hold per side state {mag[PWM_W-1:0], dir}; dir=fwd drives mag on motor pin with gnd pin low; dir=rev the converse; both pins never high together.
REQ-019 SHALL: issue a ramp tick once every RAMP_DIV cycles from a shared prescaler.
REQ-020 SHALL: per tick, same direction (or target 0): move mag toward target magnitude by RAMP_STEP, saturating exactly at target, never overshooting or wrapping.
REQ-021 SHALL: per tick, opposite direction with mag>0: decrement mag toward 0 by RAMP_STEP, saturating at 0.
REQ-022 SHALL: per side FSM RUN -> DEAD when mag==0, target nonzero and target dir != dir; DEAD holds both pins low for DEAD_CYC cycles, then flips dir and returns to RUN; ramp up starts at the next tick.
REQ-023 SHALL: in DEAD, a target change back to the current dir or to 0 abort to RUN at the next cycle without flipping dir.
REQ-024 SHALL: latch new mag/dir into applied duty only when the PWM counter wraps to 0 (glitch-free), except entering DEAD forces pins low immediately.
REQ-025 SHALL: on target change mid-ramp, continue from current mag toward the new target; no restart.
REQ-026 SHALL: settled = both sides RUN and mag == |target| and dir matches (or mag==0 and target==0).

Reset
REQ-027 SHALL: on rst_n low, asynchronously clear all pins to 0, mag to 0, dir to fwd, FSM to RUN, counters/prescaler to 0, targets to 0, settled to 1.
REQ-028 SHALL: on rst_n release mid-ramp, restart from zero; first tick occurs RAMP_DIV cycles after release.

Structure
REQ-029 SHALL: place command encodings and FSM state encoding in shared package SB_3320_motor_pkg.
REQ-030 SHALL: implement one per-side sub-module SB_3320_motor_channel (ramp, FSM, dead time, pin drive), instantiated twice; prescaler, PWM counter and command decode at top.

Verification (PWM_W=4, RAMP_DIV=4, RAMP_STEP=2, DEAD_CYC=8, DUTY_FWD=9, EXT_L=10, EXT_R=7)
REQ-031 SHALL: reset, turn=001 -> mag 0,2,4,6,8,9 on successive ticks; left_motor high 9 of 16 cycles; gnd pins never high; settled high after mag 9.
REQ-032 SHALL: forward settled, turn=010 -> left ramps 9->0, both left pins low exactly 8 cycles, then gndl ramps to 9; right unchanged.
REQ-033 SHALL: left in DEAD, turn=001 -> left returns to RUN without flip, left_motor ramps up from 0.
REQ-034 SHALL: turn=100 from stop -> gndl ramps to 10, right_motor to 7; enable=0 -> both ramp to 0, settled high.
REQ-035 SHALL: assert rst_n low mid-ramp at arbitrary phase -> all pins low same cycle; turn=111 -> behaves as stop; bench checks pin pair never both high throughout.
